// File: rtl/pal_macro_array.sv
// pal_macro_array: GAL-style programmable AND-OR array with N_OUT macrocells.
// A serial loader fills a shadow register. A commit copies the shadow into the
// active config, but only when exactly CFG_BITS bits have been shifted in.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   ena          - macrocell register enable (0 holds every q)
//   pal_in       - dedicated array inputs
//   cfg_valid    - shift cfg_data into the shadow this cycle
//   cfg_data     - configuration bit, sent MSB-first
//   cfg_commit   - request a copy of the shadow into the active config
//   pal_out      - macrocell outputs (combinational from pal_in and q in mode 00)
//   pal_oe       - per-output enable
//   cfg_done     - one-cycle pulse when a commit is accepted
//   cfg_err      - sticky bad-commit flag, cleared by the next good commit
module pal_macro_array #(
    parameter int unsigned N_IN    = 8,
    parameter int unsigned N_OUT   = 4,
    parameter int unsigned N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_IN-1:0]  pal_in,
    input  logic             cfg_valid,
    input  logic             cfg_data,
    input  logic             cfg_commit,
    output logic [N_OUT-1:0] pal_out,
    output logic [N_OUT-1:0] pal_oe,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int unsigned N_LIT    = N_IN + N_OUT;
    localparam int unsigned W        = 2 * N_LIT;
    localparam int unsigned CB       = N_TERMS * W + 4;
    localparam int unsigned CFG_BITS = N_OUT * CB;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 2);

    logic [CFG_BITS-1:0]             shadow;
    logic [CFG_BITS-1:0]             active;
    logic [CNT_W-1:0]                cnt;
    logic [N_OUT-1:0]                q;
    logic [N_OUT-1:0]                q_nxt;
    logic [N_OUT-1:0]                sum;
    logic [N_OUT-1:0]                out_c;
    logic [N_OUT-1:0]                oe_v;
    logic [N_OUT-1:0]                pol_v;
    logic [N_OUT-1:0][1:0]           mode_v;
    logic [N_OUT-1:0][N_TERMS-1:0]   terms;
    logic [W-1:0]                    term_v;
    logic [N_LIT-1:0]                lits;
    logic                            commit_ok;

    assign commit_ok = cfg_commit && (cnt == CNT_W'(CFG_BITS));
    // Feedback always comes from q, so the array has no combinational loops.
    assign lits      = {q, pal_in};

    // Serial loader and atomic commit; a commit in the same cycle drops the data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            active   <= '0;
            cnt      <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_commit) begin
                cnt <= '0;
                if (commit_ok) begin
                    active   <= shadow;
                    cfg_done <= 1'b1;
                    cfg_err  <= 1'b0;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end else if (cfg_valid) begin
                shadow <= {shadow[CFG_BITS-2:0], cfg_data};
                // Saturate one past CFG_BITS so an over-long stream stays invalid.
                if (cnt != CNT_W'(CFG_BITS + 1)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Macrocell state; a good commit clears q regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (commit_ok) begin
            q <= '0;
        end else if (ena) begin
            q <= q_nxt;
        end
    end

    // Field decode and product terms; a term with no selected literal is 0.
    always_comb begin
        oe_v   = '0;
        pol_v  = '0;
        mode_v = '0;
        terms  = '0;
        term_v = '0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            oe_v[k]   = active[k*CB + CB - 1];
            pol_v[k]  = active[k*CB + CB - 2];
            mode_v[k] = active[k*CB + CB - 4 +: 2];
            for (int t = 0; t < int'(N_TERMS); t++) begin
                term_v      = active[k*CB + t*W +: W];
                terms[k][t] = |term_v;
                for (int i = 0; i < int'(N_LIT); i++) begin
                    if (term_v[2*i] && !lits[i]) begin
                        terms[k][t] = 1'b0;
                    end
                    if (term_v[2*i+1] && lits[i]) begin
                        terms[k][t] = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cell next state and output selection.
    always_comb begin
        sum   = '0;
        q_nxt = '0;
        out_c = '0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            sum[k] = |terms[k];
            case (mode_v[k])
                2'b10:   q_nxt[k] = q[k] ^ sum[k];
                2'b11:   q_nxt[k] = terms[k][0] ? 1'b0 : |terms[k][N_TERMS-1:1];
                default: q_nxt[k] = sum[k];
            endcase
            out_c[k] = pol_v[k] ^ ((mode_v[k] == 2'b00) ? sum[k] : q[k]);
        end
    end

    assign pal_out = out_c;
    assign pal_oe  = oe_v;

endmodule

// File: tb/tb_pal_macro_array.sv
// Directed testbench for pal_macro_array with default parameters (400 config bits).
module tb_pal_macro_array;

    localparam int unsigned CFG_BITS = 400;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] pal_in;
    logic       cfg_valid;
    logic       cfg_data;
    logic       cfg_commit;
    logic [3:0] pal_out;
    logic [3:0] pal_oe;
    logic       cfg_done;
    logic       cfg_err;

    int n_cmp;
    int n_bad;

    logic [CFG_BITS-1:0] cfg_and;
    logic [CFG_BITS-1:0] cfg_tcnt;
    logic [CFG_BITS-1:0] cfg_dclr;

    pal_macro_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pal_in     (pal_in),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .pal_out    (pal_out),
        .pal_oe     (pal_oe),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Send stream bits first..last-1 (MSB-first); positions past CFG_BITS send 0.
    task automatic shift_range(input logic [CFG_BITS-1:0] v, input int first, input int last);
        for (int j = first; j < last; j++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = (j < int'(CFG_BITS)) ? v[CFG_BITS-1-j] : 1'b0;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    // Pulse cfg_commit for one edge; sample cfg_done/cfg_err after it and one cycle later.
    task automatic do_commit(input logic with_valid, output logic done_a,
                             output logic err_a, output logic done_b);
        @(negedge clk);
        cfg_commit = 1'b1;
        cfg_valid  = with_valid;
        cfg_data   = with_valid;
        @(negedge clk);
        cfg_commit = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 1'b0;
        done_a     = cfg_done;
        err_a      = cfg_err;
        @(negedge clk);
        done_b     = cfg_done;
    endtask

    task automatic test_reset();
        logic [7:0] vin [4];
        vin = '{8'h00, 8'hFF, 8'h01, 8'h3C};
        rst_n      = 1'b0;
        ena        = 1'b0;
        pal_in     = 8'hA5;
        cfg_valid  = 1'b0;
        cfg_data   = 1'b0;
        cfg_commit = 1'b0;
        #2;
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL reset_out: got %b want 0000", pal_out); end
        n_cmp++; if (pal_oe !== 4'b0000) begin n_bad++; $display("FAIL reset_oe: got %b want 0000", pal_oe); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pal_in = vin[i];
            #1;
            n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL unconfigured_out[%0d]: got %b want 0000", i, pal_out); end
        end
    endtask

    // cell0: comb, pol 0, oe 1, term0 = in0 & ~in1.
    task automatic test_comb_and();
        logic d1, e, d2;
        logic [7:0] vin [4];
        logic [3:0] vexp [4];
        vin  = '{8'h01, 8'h03, 8'h00, 8'hFD};
        vexp = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
        shift_range(cfg_and, 0, 400);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL and_done_pulse: got %b want 1", d1); end
        n_cmp++; if (d2 !== 1'b0) begin n_bad++; $display("FAIL and_done_one_cycle: got %b want 0", d2); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL and_err: got %b want 0", e); end
        n_cmp++; if (pal_oe !== 4'b0001) begin n_bad++; $display("FAIL and_oe: got %b want 0001", pal_oe); end
        for (int i = 0; i < 4; i++) begin
            pal_in = vin[i];
            #1;
            n_cmp++; if (pal_out !== vexp[i]) begin n_bad++; $display("FAIL and_out[%0d]: in=%h got %b want %b", i, vin[i], pal_out, vexp[i]); end
            @(negedge clk);
        end
    endtask

    // cell0: T with constant-1 sum; cell1: T toggled by q0 -> 2-bit counter.
    task automatic test_t_counter();
        logic d1, e, d2;
        logic [1:0] vexp [5];
        vexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ena    = 1'b0;
        pal_in = 8'h00;
        shift_range(cfg_tcnt, 0, 400);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL tcnt_done: got %b want 1", d1); end
        n_cmp++; if (pal_oe !== 4'b0011) begin n_bad++; $display("FAIL tcnt_oe: got %b want 0011", pal_oe); end
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL tcnt_start: got %b want 0000", pal_out); end
        ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (pal_out !== {2'b00, vexp[i]}) begin n_bad++; $display("FAIL tcnt_step[%0d]: got %b want %b", i, pal_out, {2'b00, vexp[i]}); end
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (pal_out !== 4'b0001) begin n_bad++; $display("FAIL tcnt_hold[%0d]: got %b want 0001", i, pal_out); end
        end
    endtask

    // cell2: D-clr, pol 1, term0 = in7 (clear), term1 = in2 (set).
    task automatic test_dclr();
        logic d1, e, d2;
        ena    = 1'b0;
        pal_in = 8'h84;
        shift_range(cfg_dclr, 0, 400);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL dclr_done: got %b want 1", d1); end
        n_cmp++; if (pal_oe !== 4'b0100) begin n_bad++; $display("FAIL dclr_oe: got %b want 0100", pal_oe); end
        n_cmp++; if (pal_out !== 4'b0100) begin n_bad++; $display("FAIL dclr_start: got %b want 0100", pal_out); end
        ena = 1'b1;
        @(negedge clk);
        n_cmp++; if (pal_out !== 4'b0100) begin n_bad++; $display("FAIL dclr_clear_wins: got %b want 0100", pal_out); end
        pal_in = 8'h04;
        #1;
        n_cmp++; if (pal_out !== 4'b0100) begin n_bad++; $display("FAIL dclr_registered: got %b want 0100", pal_out); end
        @(negedge clk);
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL dclr_set: got %b want 0000", pal_out); end
        pal_in = 8'h84;
        @(negedge clk);
        n_cmp++; if (pal_out !== 4'b0100) begin n_bad++; $display("FAIL dclr_reclear: got %b want 0100", pal_out); end
        ena = 1'b0;
    endtask

    task automatic test_bad_commit();
        logic d1, e, d2;
        pal_in = 8'h01;
        shift_range(cfg_and, 0, 399);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b want 1", e); end
        n_cmp++; if (d1 !== 1'b0) begin n_bad++; $display("FAIL short_no_done: got %b want 0", d1); end
        n_cmp++; if (pal_oe !== 4'b0100) begin n_bad++; $display("FAIL short_oe_kept: got %b want 0100", pal_oe); end
        n_cmp++; if (pal_out !== 4'b0100) begin n_bad++; $display("FAIL short_out_kept: got %b want 0100", pal_out); end
        shift_range(cfg_and, 0, 401);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL long_err: got %b want 1", e); end
        n_cmp++; if (d1 !== 1'b0) begin n_bad++; $display("FAIL long_no_done: got %b want 0", d1); end
        n_cmp++; if (pal_oe !== 4'b0100) begin n_bad++; $display("FAIL long_oe_kept: got %b want 0100", pal_oe); end
        shift_range(cfg_and, 0, 400);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL good_err_clear: got %b want 0", e); end
        n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL good_done: got %b want 1", d1); end
        n_cmp++; if (pal_oe !== 4'b0001) begin n_bad++; $display("FAIL good_oe: got %b want 0001", pal_oe); end
        n_cmp++; if (pal_out !== 4'b0001) begin n_bad++; $display("FAIL good_out: got %b want 0001", pal_out); end
    endtask

    task automatic test_simultaneous();
        logic d1, e, d2;
        shift_range(cfg_dclr, 0, 399);
        do_commit(1'b1, d1, e, d2);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL simul_err: got %b want 1", e); end
        n_cmp++; if (d1 !== 1'b0) begin n_bad++; $display("FAIL simul_no_done: got %b want 0", d1); end
        n_cmp++; if (pal_oe !== 4'b0001) begin n_bad++; $display("FAIL simul_oe_kept: got %b want 0001", pal_oe); end
        shift_range(cfg_tcnt, 0, 200);
        pal_in = 8'h01;
        #1;
        n_cmp++; if (pal_out !== 4'b0001) begin n_bad++; $display("FAIL midshift_out01: got %b want 0001", pal_out); end
        n_cmp++; if (pal_oe !== 4'b0001) begin n_bad++; $display("FAIL midshift_oe: got %b want 0001", pal_oe); end
        pal_in = 8'h03;
        #1;
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL midshift_out03: got %b want 0000", pal_out); end
        shift_range(cfg_tcnt, 200, 400);
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL split_done: got %b want 1", d1); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL split_err: got %b want 0", e); end
        n_cmp++; if (pal_oe !== 4'b0011) begin n_bad++; $display("FAIL split_oe: got %b want 0011", pal_oe); end
    endtask

    task automatic test_reset_mid();
        logic d1, e, d2;
        ena = 1'b1;
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL empty_commit_err: got %b want 1", e); end
        shift_range(cfg_and, 0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL midreset_out: got %b want 0000", pal_out); end
        n_cmp++; if (pal_oe !== 4'b0000) begin n_bad++; $display("FAIL midreset_oe: got %b want 0000", pal_oe); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b want 0", cfg_err); end
        @(negedge clk);
        rst_n  = 1'b1;
        ena    = 1'b0;
        pal_in = 8'hFF;
        #1;
        n_cmp++; if (pal_out !== 4'b0000) begin n_bad++; $display("FAIL postreset_out: got %b want 0000", pal_out); end
        do_commit(1'b0, d1, e, d2);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL postreset_cnt_lost: got %b want 1", e); end
        n_cmp++; if (d1 !== 1'b0) begin n_bad++; $display("FAIL postreset_no_done: got %b want 0", d1); end
        n_cmp++; if (pal_oe !== 4'b0000) begin n_bad++; $display("FAIL postreset_oe: got %b want 0000", pal_oe); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Cell k base = k*100: oe at +99, pol at +98, mode at +97:+96, term t at +t*24.
        // Literal i true = bit 2i, complement = bit 2i+1; q feedback literals start at i=8.
        cfg_and      = '0;
        cfg_and[99]  = 1'b1;   // cell0 oe
        cfg_and[0]   = 1'b1;   // term0: in0
        cfg_and[3]   = 1'b1;   // term0: ~in1

        cfg_tcnt      = '0;
        cfg_tcnt[99]  = 1'b1;  // cell0 oe
        cfg_tcnt[97]  = 1'b1;  // cell0 mode 10 (T)
        cfg_tcnt[0]   = 1'b1;  // cell0 term0: in0
        cfg_tcnt[25]  = 1'b1;  // cell0 term1: ~in0
        cfg_tcnt[199] = 1'b1;  // cell1 oe
        cfg_tcnt[197] = 1'b1;  // cell1 mode 10 (T)
        cfg_tcnt[116] = 1'b1;  // cell1 term0: q0

        cfg_dclr      = '0;
        cfg_dclr[299] = 1'b1;  // cell2 oe
        cfg_dclr[298] = 1'b1;  // cell2 pol
        cfg_dclr[297] = 1'b1;  // cell2 mode 11
        cfg_dclr[296] = 1'b1;
        cfg_dclr[214] = 1'b1;  // cell2 term0: in7
        cfg_dclr[228] = 1'b1;  // cell2 term1: in2

        test_reset();
        test_comb_and();
        test_t_counter();
        test_dclr();
        test_bad_commit();
        test_simultaneous();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
